// File: rtl/tl_instruction_fetch_if.sv
// Fetch-stage control/data bundle: pipeline controls, program-load write port and IF/ID outputs.
// The master side drives controls and loads the program; the slave side is the fetch stage.
interface tl_instruction_fetch_if #(
  parameter int len         = 32,
  parameter int NB_ADDR_MEM = 8
);
  logic                   i_enable;
  logic                   i_stall;
  logic                   i_flush;
  logic                   i_pc_src;
  logic [len-1:0]         i_pc_branch;
  logic                   i_wr_en;
  logic [NB_ADDR_MEM-1:0] i_wr_addr;
  logic [len-1:0]         i_wr_data;
  logic [len-1:0]         o_instruccion;
  logic [len-1:0]         o_pc_plus4;
  logic [len-1:0]         o_pc;
  logic                   o_valid;
  logic                   o_halt;

  modport master (
    output i_enable, i_stall, i_flush, i_pc_src, i_pc_branch,
    output i_wr_en, i_wr_addr, i_wr_data,
    input  o_instruccion, o_pc_plus4, o_pc, o_valid, o_halt
  );

  modport slave (
    input  i_enable, i_stall, i_flush, i_pc_src, i_pc_branch,
    input  i_wr_en, i_wr_addr, i_wr_data,
    output o_instruccion, o_pc_plus4, o_pc, o_valid, o_halt
  );
endinterface

// File: rtl/tl_instruction_fetch.sv
// IF stage + IF/ID register with internal loadable instruction memory.
// Optional halt-word detection is enabled by defining IF_HALT_DETECT_EN.
module tl_instruction_fetch #(
  parameter int          len                = 32,
  parameter int          CANT_INSTRUCCIONES = 256,
  parameter int          NB_ADDR_MEM        = $clog2(CANT_INSTRUCCIONES),
  parameter logic [31:0] PC_RESET           = '0
) (
  input logic                   i_clk,
  input logic                   i_rst,
  tl_instruction_fetch_if.slave bus
);

  logic [len-1:0]         mem [CANT_INSTRUCCIONES];
  logic [len-1:0]         pc;
  logic [len-1:0]         pc_plus4;
  logic [len-1:0]         fetch_word;
  logic [NB_ADDR_MEM-1:0] pc_idx;
  logic                   halted;
  logic                   advance;
  logic                   fetch;

  assign pc_plus4   = pc + len'(4);
  assign pc_idx     = pc[NB_ADDR_MEM+1:2];
  // Combinational read of the pre-edge contents gives read-first behaviour against the write port.
  assign fetch_word = mem[pc_idx];
  assign advance    = bus.i_enable && !halted;
  assign fetch      = advance && !bus.i_flush && !bus.i_stall;

  always_ff @(posedge i_clk) begin
    if (bus.i_wr_en) mem[bus.i_wr_addr] <= bus.i_wr_data;
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      pc <= len'(PC_RESET);
    end else if (advance) begin
      if (bus.i_pc_src)     pc <= bus.i_pc_branch & ~len'(3);
      else if (!bus.i_stall) pc <= pc_plus4;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      bus.o_instruccion <= '0;
      bus.o_pc_plus4    <= '0;
      bus.o_valid       <= 1'b0;
    end else if (advance) begin
      if (bus.i_flush) begin
        bus.o_instruccion <= '0;
        bus.o_pc_plus4    <= '0;
        bus.o_valid       <= 1'b0;
      end else if (!bus.i_stall) begin
        bus.o_instruccion <= fetch_word;
        bus.o_pc_plus4    <= pc_plus4;
        bus.o_valid       <= 1'b1;
      end
    end
  end

`ifdef IF_HALT_DETECT_EN
  typedef enum logic {ST_RUN, ST_HALT} halt_state_t;
  halt_state_t state, state_next;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) state <= ST_RUN;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (state == ST_RUN && fetch && fetch_word == '1) state_next = ST_HALT;
  end

  always_comb begin
    halted = (state == ST_HALT);
  end
`else
  assign halted = 1'b0;
  logic unused_fetch;
  assign unused_fetch = fetch;
`endif

  assign bus.o_pc   = pc;
  assign bus.o_halt = halted;

endmodule

// File: tb/tb_tl_instruction_fetch.sv
// Directed, table-driven bench for tl_instruction_fetch plus hand-written corner sequences.
// Checks the halt path when IF_HALT_DETECT_EN is defined, the plain fetch otherwise.
module tb_tl_instruction_fetch;

  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  tl_instruction_fetch_if #(.len(32), .NB_ADDR_MEM(8)) bus ();

  tl_instruction_fetch #(
    .len(32),
    .CANT_INSTRUCCIONES(256),
    .NB_ADDR_MEM(8),
    .PC_RESET(32'h0)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        en, stall, flush, src;
    logic [31:0] branch;
    logic [31:0] exp_pc, exp_ins, exp_p4;
    logic        exp_v;
  } vec_t;

  vec_t vec [19];

  function automatic logic [31:0] w(input int k);
    return 32'hA000_0000 + k;
  endfunction

  function automatic vec_t mk(input logic en, stall, flush, src, input logic [31:0] br,
                              input logic [31:0] pc, ins, p4, input logic v);
    vec_t r;
    r.en = en; r.stall = stall; r.flush = flush; r.src = src; r.branch = br;
    r.exp_pc = pc; r.exp_ins = ins; r.exp_p4 = p4; r.exp_v = v;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic en, stall, flush, src, input logic [31:0] br);
    bus.i_enable = en; bus.i_stall = stall; bus.i_flush = flush;
    bus.i_pc_src = src; bus.i_pc_branch = br;
  endtask

  task automatic check_if(input string name, input logic [31:0] pc, ins, p4, input logic v);
    check({name, ".pc"},  bus.o_pc, pc);
    check({name, ".ins"}, bus.o_instruccion, ins);
    check({name, ".p4"},  bus.o_pc_plus4, p4);
    check({name, ".v"},   {31'b0, bus.o_valid}, {31'b0, v});
  endtask

  initial begin
    //          en stall flush src branch         pc            ins      p4            v
    vec[0]  = mk(1, 0, 0, 0, 32'h0,         32'h4,        w(0),    32'h4,        1);
    vec[1]  = mk(1, 0, 0, 0, 32'h0,         32'h8,        w(1),    32'h8,        1);
    vec[2]  = mk(1, 1, 0, 0, 32'h0,         32'h8,        w(1),    32'h8,        1);
    vec[3]  = mk(1, 1, 0, 0, 32'h0,         32'h8,        w(1),    32'h8,        1);
    vec[4]  = mk(1, 0, 0, 0, 32'h0,         32'hC,        w(2),    32'hC,        1);
    vec[5]  = mk(1, 0, 0, 0, 32'h0,         32'h10,       w(3),    32'h10,       1);
    vec[6]  = mk(1, 0, 1, 1, 32'h13,        32'h10,       32'h0,   32'h0,        0);
    vec[7]  = mk(1, 0, 0, 0, 32'h0,         32'h14,       w(4),    32'h14,       1);
    vec[8]  = mk(1, 1, 0, 1, 32'h20,        32'h20,       w(4),    32'h14,       1);
    vec[9]  = mk(1, 0, 0, 0, 32'h0,         32'h24,       w(8),    32'h24,       1);
    vec[10] = mk(1, 1, 1, 0, 32'h0,         32'h24,       32'h0,   32'h0,        0);
    vec[11] = mk(0, 0, 1, 1, 32'h40,        32'h24,       32'h0,   32'h0,        0);
    vec[12] = mk(1, 0, 0, 0, 32'h0,         32'h28,       w(9),    32'h28,       1);
    vec[13] = mk(1, 0, 0, 1, 32'h3FC,       32'h3FC,      w(10),   32'h2C,       1);
    vec[14] = mk(1, 0, 0, 0, 32'h0,         32'h400,      w(255),  32'h400,      1);
    vec[15] = mk(1, 0, 0, 0, 32'h0,         32'h404,      w(0),    32'h404,      1);
    vec[16] = mk(1, 0, 0, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFC, w(1),   32'h408,      1);
    vec[17] = mk(1, 0, 0, 0, 32'h0,         32'h0,        w(255),  32'h0,        1);
    vec[18] = mk(1, 0, 0, 0, 32'h0,         32'h4,        w(0),    32'h4,        1);

    rst = 1'b0;
    drive(1, 0, 0, 0, 32'h0);
    bus.i_wr_en = 1'b0; bus.i_wr_addr = '0; bus.i_wr_data = '0;
    #2;
    for (int unsigned k = 0; k < 256; k++) begin
      bus.i_wr_en = 1'b1; bus.i_wr_addr = 8'(k); bus.i_wr_data = w(int'(k));
      step();
    end
    bus.i_wr_en = 1'b0;
    check_if("reset", 32'h0, 32'h0, 32'h0, 1'b0);
    check("reset.halt", {31'b0, bus.o_halt}, 32'h0);
    rst = 1'b1;

    for (int i = 0; i < 19; i++) begin
      drive(vec[i].en, vec[i].stall, vec[i].flush, vec[i].src, vec[i].branch);
      step();
      check_if($sformatf("vec%0d", i), vec[i].exp_pc, vec[i].exp_ins, vec[i].exp_p4, vec[i].exp_v);
    end

    // Read-first: overwrite mem[1] on the same edge that fetches it.
    drive(1, 0, 0, 0, 32'h0);
    bus.i_wr_en = 1'b1; bus.i_wr_addr = 8'd1; bus.i_wr_data = 32'h1234_5678;
    step();
    bus.i_wr_en = 1'b0;
    check_if("rdfirst", 32'h8, w(1), 32'h8, 1'b1);
    // Write while frozen still lands in memory.
    drive(0, 0, 0, 0, 32'h0);
    bus.i_wr_en = 1'b1; bus.i_wr_addr = 8'd2; bus.i_wr_data = 32'hCAFE_0002;
    step();
    bus.i_wr_en = 1'b0;
    check_if("frozen_wr", 32'h8, w(1), 32'h8, 1'b1);
    drive(1, 0, 0, 1, 32'h4);
    step();
    check_if("refetch2", 32'h4, 32'hCAFE_0002, 32'hC, 1'b1);
    drive(1, 0, 0, 0, 32'h0);
    step();
    check_if("newdata1", 32'h8, 32'h1234_5678, 32'h8, 1'b1);

    // Asynchronous reset between edges.
    #2;
    rst = 1'b0;
    #1;
    check_if("async_rst", 32'h0, 32'h0, 32'h0, 1'b0);
    rst = 1'b1;
    step();
    check_if("restart", 32'h4, w(0), 32'h4, 1'b1);

    // Halt word at mem[2]
    rst = 1'b0;
    bus.i_wr_en = 1'b1; bus.i_wr_addr = 8'd2; bus.i_wr_data = 32'hFFFF_FFFF;
    step();
    bus.i_wr_en = 1'b0;
    rst = 1'b1;
    step();
    step();
    check("halt.pre_pc", bus.o_pc, 32'h8);
    step();
    check_if("halt.fetch", 32'hC, 32'hFFFF_FFFF, 32'hC, 1'b1);
`ifdef IF_HALT_DETECT_EN
    check("halt.flag", {31'b0, bus.o_halt}, 32'h1);
    drive(1, 0, 0, 1, 32'h80);
    for (int i = 0; i < 10; i++) begin
      step();
      check_if($sformatf("halted%0d", i), 32'hC, 32'hFFFF_FFFF, 32'hC, 1'b1);
      check($sformatf("halted%0d.flag", i), {31'b0, bus.o_halt}, 32'h1);
    end
`else
    check("nohalt.flag", {31'b0, bus.o_halt}, 32'h0);
    step();
    check_if("nohalt.next", 32'h10, w(3), 32'h10, 1'b1);
    check("nohalt.flag2", {31'b0, bus.o_halt}, 32'h0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
